seg_scan_decoder: RTL and testbench

Receive-side counterpart of the stopwatch's multiplexed seven-segment driver. Samples the active-high segment bus and one-hot digit-select bus once each digit has settled, then decodes each glyph back to BCD. Assembles complete four-digit frames and presents `min1/min2/sec1/sec2` with a one-cycle frame strobe. Used as the display self-check monitor and as the loopback target in board-level verification.

---
 rtl/seg_scan_decoder_pkg.sv | 37 +++
 rtl/seg_scan_decoder_if.sv | 24 ++
 rtl/seg_scan_decoder_seg7_to_bcd.sv | 31 +++
 rtl/seg_scan_decoder.sv | 133 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the seven-segment scan decoder: glyph encodings,
// digit slot indices and bus widths.
package seg_scan_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIG_W   = 4;
    localparam int unsigned VAL_W   = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned DWELL_W = 8;

    // Segment order a..g maps to seg[6]..seg[0]
    localparam logic [SEG_W-1:0] GLYPH_0     = 7'h7E;
    localparam logic [SEG_W-1:0] GLYPH_1     = 7'h30;
    localparam logic [SEG_W-1:0] GLYPH_2     = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_3     = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_4     = 7'h33;
    localparam logic [SEG_W-1:0] GLYPH_5     = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_6     = 7'h5F;
    localparam logic [SEG_W-1:0] GLYPH_7     = 7'h70;
    localparam logic [SEG_W-1:0] GLYPH_8     = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9     = 7'h7B;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h00;

    localparam logic [IDX_W-1:0] IDX_MIN1 = 2'd0;
    localparam logic [IDX_W-1:0] IDX_MIN2 = 2'd1;
    localparam logic [IDX_W-1:0] IDX_SEC1 = 2'd2;
    localparam logic [IDX_W-1:0] IDX_SEC2 = 2'd3;

    localparam logic [VAL_W-1:0] TENS_MAX = 4'd5;

    typedef logic [VAL_W-1:0] bcd_t;

    function automatic logic is_tens(input logic [IDX_W-1:0] idx);
        return (idx == IDX_MIN1) || (idx == IDX_SEC1);
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display scan bus (segments + digit select) and the decoded frame outputs.
interface seg_scan_if;
    import seg_scan_pkg::*;

    logic [SEG_W-1:0] seg;
    logic [DIG_W-1:0] dig;
    logic [2:0]       min1;
    logic [3:0]       min2;
    logic [2:0]       sec1;
    logic [3:0]       sec2;
    logic [DIG_W-1:0] blank;
    logic             frame_valid;
    logic             err;

    modport master (
        output seg, dig,
        input  min1, min2, sec1, sec2, blank, frame_valid, err
    );

    modport slave (
        input  seg, dig,
        output min1, min2, sec1, sec2, blank, frame_valid, err
    );
endinterface

// File: rtl/seg_scan_decoder_seg7_to_bcd.sv
// Combinational glyph-to-BCD lookup; anything outside the table is illegal.
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output bcd_t             val_o,
    output logic             is_blank_o,
    output logic             illegal_o
);

    always_comb begin
        val_o      = '0;
        is_blank_o = 1'b0;
        illegal_o  = 1'b0;
        unique case (seg_i)
            GLYPH_0:     val_o = 4'd0;
            GLYPH_1:     val_o = 4'd1;
            GLYPH_2:     val_o = 4'd2;
            GLYPH_3:     val_o = 4'd3;
            GLYPH_4:     val_o = 4'd4;
            GLYPH_5:     val_o = 4'd5;
            GLYPH_6:     val_o = 4'd6;
            GLYPH_7:     val_o = 4'd7;
            GLYPH_8:     val_o = 4'd8;
            GLYPH_9:     val_o = 4'd9;
            GLYPH_BLANK: is_blank_o = 1'b1;
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed seven-segment scan once per settled digit and
// reassembles complete four-digit frames with a one-cycle frame strobe.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);

    localparam logic [DWELL_W-1:0] DWELL_SAT = DWELL_W'(SETTLE_CYCLES);
    localparam logic [DWELL_W-1:0] SAMPLE_AT = DWELL_W'(SETTLE_CYCLES - 1);

    logic [DIG_W-1:0]   dig_q;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               done_q, done_d;
    logic [DIG_W-1:0]   mask_q, mask_d;
    bcd_t [DIG_W-1:0]   shadow_q, shadow_d;
    logic [DIG_W-1:0]   sblank_q, sblank_d;

    logic [2:0]         min1_q, sec1_q;
    logic [3:0]         min2_q, sec2_q;
    logic [DIG_W-1:0]   blank_q;
    logic               frame_valid_q, err_q;

    bcd_t               dec_val;
    logic               dec_blank, dec_illegal;
    logic               dig_chg, one_hot, multi_hot, done_eff;
    logic               sample, bad, good, complete, err_d;
    logic [IDX_W-1:0]   idx;

    seg7_to_bcd u_dec (
        .seg_i      (bus.seg),
        .val_o      (dec_val),
        .is_blank_o (dec_blank),
        .illegal_o  (dec_illegal)
    );

    // Dwell tracking, sample qualification and shadow/mask update
    always_comb begin
        dig_chg   = (bus.dig != dig_q);
        one_hot   = $onehot(bus.dig);
        multi_hot = (bus.dig != '0) && !one_hot;
        dwell_d   = '0;
        if (!dig_chg) begin
            dwell_d = (dwell_q >= DWELL_SAT) ? dwell_q : DWELL_W'(dwell_q + 8'd1);
        end
        done_eff  = done_q && !dig_chg;

        idx = IDX_MIN1;
        unique case (bus.dig)
            4'b0010: idx = IDX_MIN2;
            4'b0100: idx = IDX_SEC1;
            4'b1000: idx = IDX_SEC2;
            default: idx = IDX_MIN1;
        endcase

        sample = one_hot && (dwell_d == SAMPLE_AT) && !done_eff;
        bad    = dec_illegal || (is_tens(idx) && !dec_blank && (dec_val > TENS_MAX));
        good   = sample && !bad;
        done_d = done_eff || sample;
        err_d  = (sample && bad) || (multi_hot && dig_chg);

        shadow_d = shadow_q;
        sblank_d = sblank_q;
        mask_d   = mask_q;
        if (good) begin
            if (dec_blank) begin
                sblank_d[idx] = 1'b1;
            end else begin
                shadow_d[idx] = dec_val;
                sblank_d[idx] = 1'b0;
            end
            mask_d[idx] = 1'b1;
        end
        complete = good && (mask_d == 4'hF);
        if (complete) begin
            mask_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q    <= '0;
            dwell_q  <= '0;
            done_q   <= 1'b0;
            mask_q   <= '0;
            shadow_q <= '0;
            sblank_q <= '0;
        end else begin
            dig_q    <= bus.dig;
            dwell_q  <= dwell_d;
            done_q   <= done_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            sblank_q <= sblank_d;
        end
    end

    // Output stage: new frame values and the strobe land on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min1_q        <= '0;
            min2_q        <= '0;
            sec1_q        <= '0;
            sec2_q        <= '0;
            blank_q       <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            frame_valid_q <= complete;
            err_q         <= err_d;
            if (complete) begin
                min1_q  <= shadow_d[IDX_MIN1][2:0];
                min2_q  <= shadow_d[IDX_MIN2];
                sec1_q  <= shadow_d[IDX_SEC1][2:0];
                sec2_q  <= shadow_d[IDX_SEC2];
                blank_q <= sblank_d;
            end
        end
    end

    assign bus.min1        = min1_q;
    assign bus.min2        = min2_q;
    assign bus.sec1        = sec1_q;
    assign bus.sec2        = sec2_q;
    assign bus.blank       = blank_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed and randomized scan sequences checked against a per-dwell
// behavioural model of the display monitor.
module tb_seg_scan_decoder;

    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_scan_if bus ();

    seg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0, failures = 0;
    int frames_seen = 0, errs_seen = 0;
    int exp_frames = 0, exp_errs = 0;
    int sh[4], o[4];
    bit shb[4], msk[4], ob[4];
    logic [3:0] prev_dig;
    logic [6:0] glyph [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) frames_seen++;
        if (bus.err === 1'b1) errs_seen++;
    end

    // Returns 0..9 for a digit, 10 for blank, -1 for an illegal pattern
    function automatic int dec(input logic [6:0] s);
        if (s == 7'h00) return 10;
        for (int i = 0; i < 10; i++) if (glyph[i] == s) return i;
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold one scan value for len cycles, then apply the display rules to the model
    task automatic scan(input logic [3:0] d, input logic [6:0] s, input int len);
        int v, idx;
        bus.dig = d;
        bus.seg = s;
        repeat (len) cyc();
        if ($countones(d) == 1 && len >= int'(S)) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (d[i]) idx = i;
            v = dec(s);
            if (v < 0 || (v != 10 && v > 5 && (idx == 0 || idx == 2))) begin
                exp_errs++;
            end else begin
                if (v == 10) shb[idx] = 1'b1;
                else begin sh[idx] = v; shb[idx] = 1'b0; end
                msk[idx] = 1'b1;
                if (msk[0] && msk[1] && msk[2] && msk[3]) begin
                    o = sh;
                    ob = shb;
                    exp_frames++;
                    msk = '{default: 1'b0};
                end
            end
        end else if ($countones(d) > 1 && d != prev_dig) begin
            exp_errs++;
        end
        prev_dig = d;
    endtask

    task automatic gap(input int n);
        scan(4'b0000, 7'($urandom), n);
    endtask

    task automatic sd(input int i, input logic [6:0] g, input int len);
        scan(4'(1 << i), g, len);
        gap(int'($urandom_range(1, 2)));
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_frames"}, frames_seen, exp_frames);
        chk({tag, "_errs"},   errs_seen,   exp_errs);
        chk({tag, "_min1"},   bus.min1,    o[0]);
        chk({tag, "_min2"},   bus.min2,    o[1]);
        chk({tag, "_sec1"},   bus.sec1,    o[2]);
        chk({tag, "_sec2"},   bus.sec2,    o[3]);
        chk({tag, "_blank"},  bus.blank,   {ob[3], ob[2], ob[1], ob[0]});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_min1"},  bus.min1,        0);
        chk({tag, "_min2"},  bus.min2,        0);
        chk({tag, "_sec1"},  bus.sec1,        0);
        chk({tag, "_sec2"},  bus.sec2,        0);
        chk({tag, "_blank"}, bus.blank,       0);
        chk({tag, "_fv"},    bus.frame_valid, 0);
        chk({tag, "_err"},   bus.err,         0);
    endtask

    task automatic model_reset();
        sh = '{default: 0};
        o = '{default: 0};
        shb = '{default: 1'b0};
        ob = '{default: 1'b0};
        msk = '{default: 1'b0};
        prev_dig = 4'b0000;
    endtask

    initial begin
        logic [3:0] d;
        logic [6:0] g;
        int r, idx, len;

        rst_n = 1'b0;
        bus.dig = '0;
        bus.seg = '0;
        model_reset();
        repeat (3) cyc();
        chk_zero("reset");
        rst_n = 1'b1;
        cyc();

        // Basic frame 12:34
        sd(0, 7'h30, 6); sd(1, 7'h6D, 6); sd(2, 7'h79, 6); sd(3, 7'h33, 6);
        chk_all("frame1234");
        chk("t1_frames", frames_seen, 1);
        chk("t1_min1", bus.min1, 1);
        chk("t1_sec2", bus.sec2, 4);
        chk("t1_blank", bus.blank, 0);

        // Short dwell on sec2 yields no sample; exact-settle dwell does
        sd(0, 7'h5B, 6); sd(1, 7'h7B, 6); sd(2, 7'h7E, 6); sd(3, 7'h7F, 3);
        chk_all("short_dwell");
        chk("t2_no_frame", frames_seen, 1);
        sd(3, 7'h7F, 4);
        chk_all("settle_exact");
        chk("t2_min1", bus.min1, 5);

        // Out-of-range tens digit, then a good resample
        sd(0, 7'h30, 6); sd(1, 7'h6D, 6); sd(2, 7'h5F, 6); sd(3, 7'h33, 6);
        chk_all("tens_bad");
        chk("t3_err", errs_seen, 1);
        sd(2, 7'h5B, 6);
        chk_all("tens_fix");
        chk("t3_sec1", bus.sec1, 5);

        // Multi-hot select held: single error, mask preserved
        sd(0, 7'h33, 6); sd(1, 7'h70, 6); sd(2, 7'h6D, 6);
        scan(4'b0011, 7'h30, 10); gap(1);
        chk_all("multihot");
        chk("t4_err", errs_seen, 2);
        sd(3, 7'h5F, 6);
        chk_all("multihot_done");

        // Illegal glyph held indefinitely errors exactly once
        scan(4'b0001, 7'h01, 40); gap(1);
        chk_all("illegal_hold");

        // Blank minutes keep their last lit values
        sd(0, 7'h30, 6); sd(1, 7'h6D, 6); sd(2, 7'h79, 6); sd(3, 7'h33, 6);
        sd(0, 7'h00, 6); sd(1, 7'h00, 6); sd(2, 7'h7E, 6); sd(3, 7'h7E, 6);
        chk_all("blank_min");
        chk("t5_blank", bus.blank, 4'b0011);
        chk("t5_min2", bus.min2, 2);

        // Reset mid-frame discards the partial frame
        sd(0, 7'h33, 6); sd(1, 7'h33, 6); sd(2, 7'h33, 6);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_zero("midreset");
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        sd(0, 7'h6D, 6); sd(1, 7'h5B, 6); sd(2, 7'h30, 6);
        chk_all("post_reset3");
        sd(3, 7'h7B, 6);
        chk_all("post_reset4");

        // Randomized scans
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 99));
            idx = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, 9));
            if (r < 8) begin
                do d = 4'($urandom); while ($countones(d) < 2);
                scan(d, 7'($urandom), len);
                gap(int'($urandom_range(1, 2)));
            end else begin
                if (r < 18) begin
                    do g = 7'($urandom); while (dec(g) != -1);
                end else if (r < 28) begin
                    g = 7'h00;
                end else begin
                    g = glyph[$urandom_range(0, 9)];
                end
                sd(idx, g, len);
            end
            if (n % 10 == 9) chk_all("rand");
        end
        chk_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
